// File: rtl/arrow_judge_if.sv
// Signal bundle between the arrow judge and its surroundings.
// The generator, buttons, display and score path all attach here; the slave side is the judge itself.
interface arrow_judge_if;
    logic       tick;
    logic [1:0] state;
    logic [4:0] arrow_in;
    logic [3:0] btn;
    logic       arrow_take;
    logic [1:0] target_dir;
    logic       target_valid;
    logic [7:0] time_left;
    logic       hit;
    logic       miss;
    logic [6:0] score;
    logic [1:0] lives;
    logic       game_over;

    modport slave (
        input  tick, state, arrow_in, btn,
        output arrow_take, target_dir, target_valid, time_left,
               hit, miss, score, lives, game_over
    );

    modport master (
        output tick, state, arrow_in, btn,
        input  arrow_take, target_dir, target_valid, time_left,
               hit, miss, score, lives, game_over
    );
endinterface

// File: rtl/arrow_judge.sv
// Arrow judge: latches an arrow, times the player's response window and scores hit/miss.
// Keeps score, lives and a window that shrinks every SPEEDUP_HITS hits.
module arrow_judge #(
    parameter logic [1:0] PLAY_STATE   = 2'd1,
    parameter logic [1:0] RESET_STATE  = 2'd2,
    parameter int         LIVES        = 3,
    parameter int         WINDOW_INIT  = 200,
    parameter int         WINDOW_STEP  = 20,
    parameter int         WINDOW_MIN   = 40,
    parameter int         SPEEDUP_HITS = 5,
    parameter int         SCORE_MAX    = 99
) (
    input  logic          clk,
    input  logic          rst_n,
    arrow_judge_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_REL, ARMED, JUDGE, GAMEOVER} fsm_t;

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [7:0] WIN_INIT   = 8'(WINDOW_INIT);
    localparam logic [7:0] WIN_MIN    = 8'(WINDOW_MIN);
    localparam logic [6:0] SCORE_TOP  = 7'(SCORE_MAX);
    localparam logic [7:0] HITS_LAST  = 8'(SPEEDUP_HITS - 1);

    fsm_t       fsm;
    logic [3:0] btn_q;
    logic [7:0] window;
    logic [7:0] hit_cnt;
    logic [3:0] press;
    logic [3:0] target_oh;
    logic       good_press;
    logic       playing;
    logic [7:0] window_next;
    logic       unused_arrow;

    assign press      = bus.btn & ~btn_q;
    assign target_oh  = 4'b0001 << bus.target_dir;
    // The whole button word must equal the target too, so mashing extra buttons is a miss.
    assign good_press = (press == target_oh) && (bus.btn == target_oh);
    assign playing    = (bus.state == PLAY_STATE);
    assign unused_arrow = ^bus.arrow_in[4:2];

    // Signed int arithmetic keeps the shrink from wrapping below the floor.
    assign window_next = (int'(window) - WINDOW_STEP >= WINDOW_MIN)
                       ? 8'(int'(window) - WINDOW_STEP) : WIN_MIN;

    // NOTE: btn_q sits in its own block because only rst_n clears it; a game reset must
    // keep sampling the buttons so a held button is not seen as a fresh press afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) btn_q <= '0;
        else        btn_q <= bus.btn;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.state == RESET_STATE) begin
            fsm              <= IDLE;
            window           <= WIN_INIT;
            hit_cnt          <= '0;
            bus.score        <= '0;
            bus.lives        <= LIVES_INIT;
            bus.time_left    <= '0;
            bus.target_dir   <= '0;
            bus.arrow_take   <= 1'b0;
            bus.target_valid <= 1'b0;
            bus.hit          <= 1'b0;
            bus.miss         <= 1'b0;
            bus.game_over    <= 1'b0;
        end else begin
            // NOTE: pulses default low and are set on the transition into the state that
            // owns them, so each is a registered one-cycle strobe aligned with that state.
            bus.arrow_take <= 1'b0;
            bus.hit        <= 1'b0;
            bus.miss       <= 1'b0;
            unique case (fsm)
                IDLE: begin
                    if (playing) begin
                        fsm            <= LOAD;
                        bus.arrow_take <= 1'b1;
                    end
                end
                LOAD: begin
                    bus.target_dir <= bus.arrow_in[1:0];
                    bus.time_left  <= window;
                    fsm            <= WAIT_REL;
                end
                WAIT_REL: begin
                    if (!playing) begin
                        fsm <= IDLE;
                    end else if (bus.btn == 4'b0000) begin
                        fsm              <= ARMED;
                        bus.target_valid <= 1'b1;
                    end
                end
                ARMED: begin
                    if (!playing) begin
                        fsm              <= IDLE;
                        bus.target_valid <= 1'b0;
                    end else if (press != 4'b0000) begin
                        fsm              <= JUDGE;
                        bus.target_valid <= 1'b0;
                        bus.hit          <= good_press;
                        bus.miss         <= !good_press;
                    end else if (bus.tick) begin
                        if (bus.time_left == 8'd1) begin
                            bus.time_left    <= 8'd0;
                            bus.miss         <= 1'b1;
                            bus.target_valid <= 1'b0;
                            fsm              <= JUDGE;
                        end else begin
                            bus.time_left <= bus.time_left - 8'd1;
                        end
                    end
                end
                JUDGE: begin
                    if (bus.hit) begin
                        bus.score <= (bus.score >= SCORE_TOP) ? SCORE_TOP : bus.score + 7'd1;
                        if (hit_cnt >= HITS_LAST) begin
                            hit_cnt <= '0;
                            window  <= window_next;
                        end else begin
                            hit_cnt <= hit_cnt + 8'd1;
                        end
                    end
                    if (bus.miss && bus.lives == 2'd1) begin
                        bus.lives     <= 2'd0;
                        bus.game_over <= 1'b1;
                        fsm           <= GAMEOVER;
                    end else begin
                        if (bus.miss) bus.lives <= bus.lives - 2'd1;
                        if (playing) begin
                            fsm            <= LOAD;
                            bus.arrow_take <= 1'b1;
                        end else begin
                            fsm <= IDLE;
                        end
                    end
                end
                GAMEOVER: begin
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arrow_judge.sv
// Randomised scoreboard bench for arrow_judge: the driver pushes expected judgements,
// a negedge monitor pops and compares them whenever hit or miss pulses.
module tb_arrow_judge;

    localparam int W_INIT = 200;
    localparam int W_STEP = 20;
    localparam int W_MIN  = 40;
    localparam int SPEED  = 5;
    localparam int S_MAX  = 99;
    localparam int L_INIT = 3;

    localparam int K_HIT     = 0;
    localparam int K_WRONG   = 1;
    localparam int K_TIMEOUT = 2;
    localparam int K_LAST    = 3;
    localparam int K_HOLD    = 4;

    typedef struct {
        bit is_hit;
        int score;
        int lives;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    arrow_judge_if bus();

    arrow_judge dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    int take_cnt = 0;
    int take_seen = 0;
    int m_hits = 0;
    int m_misses = 0;
    logic [4:0] cur_arrow;
    bit post_pending = 0;
    exp_t post_item;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_window();
        int w;
        w = W_INIT - W_STEP * (m_hits / SPEED);
        return (w < W_MIN) ? W_MIN : w;
    endfunction

    function automatic int model_score();
        return (m_hits > S_MAX) ? S_MAX : m_hits;
    endfunction

    function automatic logic [4:0] rand_arrow();
        return 5'($urandom_range(10, 20));
    endfunction

    // Monitor: counts arrow_take pulses and pops the scoreboard on every judgement.
    always @(negedge clk) begin
        exp_t e;
        if (post_pending) begin
            post_pending = 0;
            check("score_after", bus.score, post_item.score);
            check("lives_after", bus.lives, post_item.lives);
            check("game_over_flag", bus.game_over, int'(post_item.lives == 0));
        end
        if (rst_n && bus.arrow_take) take_cnt++;
        if (rst_n && (bus.hit || bus.miss)) begin
            if (sb.size() == 0) begin
                check("unexpected_judge", int'(bus.hit) + int'(bus.miss), 0);
            end else begin
                e = sb.pop_front();
                check("judge_hit", bus.hit, int'(e.is_hit));
                check("judge_miss", bus.miss, int'(!e.is_hit));
                post_item = e;
                post_pending = 1;
            end
        end
    end

    task automatic reset_model();
        m_hits = 0;
        m_misses = 0;
        sb.delete();
    endtask

    task automatic decide(input bit is_hit, input logic [4:0] next_arrow);
        exp_t e;
        if (is_hit) m_hits++;
        else        m_misses++;
        e.is_hit = is_hit;
        e.score  = model_score();
        e.lives  = L_INIT - m_misses;
        sb.push_back(e);
        take_seen = take_cnt;
        cur_arrow = next_arrow;
        bus.arrow_in = next_arrow;
    endtask

    task automatic wait_take();
        for (int i = 0; i < 300 && take_cnt <= take_seen; i++) @(negedge clk);
        check("arrow_take_seen", int'(take_cnt > take_seen), 1);
        take_seen = take_cnt;
    endtask

    task automatic wait_armed();
        for (int i = 0; i < 100 && !bus.target_valid; i++) @(negedge clk);
        check("armed_seen", bus.target_valid, 1);
    endtask

    task automatic wait_judged();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("judged_in_time", sb.size(), 0);
    endtask

    task automatic do_round(input int kind, input int pre_ticks,
                            input logic [3:0] wrong_btn, input logic [4:0] next_arrow);
        logic [1:0] dir;
        logic [3:0] oh;
        logic [3:0] alt;
        int rem;
        dir = cur_arrow[1:0];
        oh  = 4'b0001 << dir;
        wait_take();
        @(negedge clk);
        check("target_dir", bus.target_dir, int'(dir));
        check("load_window", bus.time_left, model_window());
        if (kind == K_HOLD) begin
            repeat (8) begin
                bus.tick = 1'b1;
                @(negedge clk);
            end
            bus.tick = 1'b0;
            check("hold_not_armed", bus.target_valid, 0);
            check("hold_frozen", bus.time_left, model_window());
            bus.btn = 4'b0000;
        end
        wait_armed();
        if (pre_ticks > 0) begin
            repeat (pre_ticks) begin
                bus.tick = 1'b1;
                @(negedge clk);
            end
            bus.tick = 1'b0;
            check("time_left_count", bus.time_left, model_window() - pre_ticks);
        end
        rem = model_window() - pre_ticks;
        alt = (wrong_btn != 4'b0000) ? wrong_btn : (4'b0001 << (dir + 2'($urandom_range(1, 3))));
        case (kind)
            K_WRONG: begin
                decide(1'b0, next_arrow);
                bus.btn = alt;
            end
            K_TIMEOUT, K_LAST: begin
                repeat (rem - 1) begin
                    bus.tick = 1'b1;
                    @(negedge clk);
                end
                check("before_last_tick", bus.time_left, 1);
                bus.tick = 1'b1;
                if (kind == K_LAST) begin
                    bus.btn = oh;
                    decide(1'b1, next_arrow);
                end else begin
                    decide(1'b0, next_arrow);
                end
            end
            default: begin
                decide(1'b1, next_arrow);
                bus.btn = oh;
            end
        endcase
        @(negedge clk);
        bus.tick = 1'b0;
        if (kind == K_TIMEOUT) check("timeout_time_left", bus.time_left, 0);
        wait_judged();
        bus.btn = 4'b0000;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_score"}, bus.score, 0);
        check({tag, "_lives"}, bus.lives, L_INIT);
        check({tag, "_time_left"}, bus.time_left, 0);
        check({tag, "_valid"}, bus.target_valid, 0);
        check({tag, "_game_over"}, bus.game_over, 0);
        check({tag, "_dir"}, bus.target_dir, 0);
        check({tag, "_pulses"}, int'(bus.hit) + int'(bus.miss) + int'(bus.arrow_take), 0);
    endtask

    task automatic game_reset_and_play(input logic [4:0] first_arrow);
        @(negedge clk);
        bus.state = 2'd2;
        @(negedge clk);
        check_cleared("state_reset");
        reset_model();
        bus.state = 2'd0;
        cur_arrow = first_arrow;
        bus.arrow_in = first_arrow;
        @(negedge clk);
        take_seen = take_cnt;
        bus.state = 2'd1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.tick = 1'b0;
        bus.state = 2'd0;
        bus.arrow_in = 5'd0;
        bus.btn = 4'b0000;
        repeat (3) @(negedge clk);
        check_cleared("por");
        rst_n = 1'b1;

        // Directed opening: hit on dir 1, wrong single press, multi-button press.
        cur_arrow = 5'd13;
        bus.arrow_in = 5'd13;
        take_seen = take_cnt;
        bus.state = 2'd1;
        do_round(K_HIT, 0, 4'b0000, 5'd12);
        do_round(K_WRONG, 0, 4'b0100, 5'd13);
        do_round(K_WRONG, 0, 4'b0011, rand_arrow());
        game_reset_and_play(rand_arrow());
        do_round(K_HIT, 2, 4'b0000, rand_arrow());

        // Leave play mid-ARMED: no judgement, score/lives held.
        wait_take();
        wait_armed();
        bus.state = 2'd0;
        repeat (3) @(negedge clk);
        check("leave_valid", bus.target_valid, 0);
        check("leave_score", bus.score, model_score());
        check("leave_lives", bus.lives, L_INIT - m_misses);

        // Re-entry with a button already held on dir 0.
        cur_arrow = 5'd12;
        bus.arrow_in = 5'd12;
        bus.btn = 4'b0001;
        take_seen = take_cnt;
        bus.state = 2'd1;
        do_round(K_HOLD, 0, 4'b0000, rand_arrow());

        do_round(K_TIMEOUT, 0, 4'b0000, rand_arrow());
        do_round(K_LAST, 3, 4'b0000, rand_arrow());

        for (int i = 0; i < 117; i++)
            do_round(K_HIT, $urandom_range(0, 4), 4'b0000, rand_arrow());
        @(negedge clk);
        check("hits_total_score", bus.score, S_MAX);
        check("window_floor_model", model_window(), W_MIN);

        // Burn the remaining lives.
        do_round(K_WRONG, 1, 4'b0000, rand_arrow());
        do_round(K_WRONG, 0, 4'b0000, rand_arrow());
        repeat (20) @(negedge clk);
        check("gameover_flag", bus.game_over, 1);
        check("gameover_lives", bus.lives, 0);
        check("gameover_score", bus.score, S_MAX);
        check("gameover_no_take", take_cnt - take_seen, 0);

        game_reset_and_play(5'd13);
        do_round(K_HIT, 1, 4'b0000, 5'd15);

        // Hard reset while ARMED with ticks already consumed.
        wait_take();
        wait_armed();
        repeat (4) begin
            bus.tick = 1'b1;
            @(negedge clk);
        end
        bus.tick = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_cleared("rst_armed");
        reset_model();
        rst_n = 1'b1;
        bus.state = 2'd0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arrow_judge.md
Name: arrow_judge

Overview:
- Consumer side of the random arrow generator: latches one arrow value, presents its direction to the display, times the player's response window, and judges the button press as hit or miss.
- Maintains score, lives and a shrinking response window, and raises game_over when lives reach zero.
- Sits between the random generator and the display/score path, and is gated by the top-level 2-bit game state.

Parameters:
- PLAY_STATE, 1, game state value in which judging runs
- RESET_STATE, 2, game state value that reinitialises the block
- LIVES, 3, lives at start of game (1..3)
- WINDOW_INIT, 200, initial response window in ticks (1..255)
- WINDOW_STEP, 20, window reduction per speed-up
- WINDOW_MIN, 40, window floor
- SPEEDUP_HITS, 5, consecutive-or-not hit count between speed-ups
- SCORE_MAX, 99, score saturation value

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- tick  in  1  one-cycle timing enable (e.g. 1 kHz)
- state  in  2  top-level game state
- arrow_in  in  5  arrow value from generator (10..20)
- btn  in  4  debounced direction buttons, level; bit0 up, bit1 down, bit2 left, bit3 right
- arrow_take  out  1  one-cycle pulse when arrow_in is latched
- target_dir  out  2  latched direction = arrow_in[1:0] at latch
- target_valid  out  1  high while the player may respond (ARMED)
- time_left  out  8  remaining ticks in current window
- hit  out  1  one-cycle pulse on correct press
- miss  out  1  one-cycle pulse on wrong press or timeout
- score  out  7  hit count, saturating at SCORE_MAX
- lives  out  2  remaining lives
- game_over  out  1  high in GAMEOVER

Behaviour:
- Reset (rst_n=0 at posedge): FSM=IDLE; score=0, lives=LIVES, window=WINDOW_INIT, hit counter=0, time_left=0, target_dir=0, all pulses/flags 0, btn_q=0.
- state==RESET_STATE has the same effect as reset from any FSM state, except that btn_q keeps sampling.
- btn_q registers btn every cycle. press = btn & ~btn_q.
- IDLE: go to LOAD when state==PLAY_STATE.
- LOAD (1 cycle): pulse arrow_take; target_dir<=arrow_in[1:0]; time_left<=window; go to WAIT_REL.
- WAIT_REL: timer frozen. Go to ARMED the first cycle btn==0; this blocks a held button from scoring.
- ARMED: target_valid=1.
  - Any press!=0: if press==onehot(target_dir) and btn==onehot(target_dir), judge hit; else judge miss.
  - Else, on tick: if time_left==1, judge miss; else time_left decrements.
  - A press and the final tick in the same cycle: the press is judged, the timeout is ignored.
- JUDGE (1 cycle): hit or miss pulses exactly one cycle, registered, the cycle after the decision.
  - Hit: score<=min(score+1,SCORE_MAX); hit counter++. When it reaches SPEEDUP_HITS, counter<=0 and window<=max(window-WINDOW_STEP,WINDOW_MIN). The subtraction must not underflow.
  - Miss: lives--.
  - Next state: GAMEOVER if lives becomes 0; else LOAD if state==PLAY_STATE, else IDLE.
- GAMEOVER: game_over=1; score and lives held; wait for state==RESET_STATE.
- If state leaves PLAY_STATE (not to RESET_STATE) while in WAIT_REL or ARMED: go to IDLE, with score, lives and window held and no judgement. Re-entry starts with LOAD.
- time_left holds its value outside ARMED. It is 0 only after reset or a timeout.

Test Plan:
- Reset, state=1, arrow_in=13 (dir 1), btn=0 then btn=4'b0010 → arrow_take once, target_dir=1, hit pulse 1 cycle, score=1, lives=3.
- arrow_in=12 (dir 0), press btn=4'b0100 → miss, lives 3→2, score unchanged. Then press 4'b0011 on dir 1 → miss (multi-button).
- Hold btn=4'b0001 across LOAD on dir 0 → no hit until release and re-press; timer frozen during hold.
- No press, 200 ticks → miss exactly on the 200th tick, time_left=0. Press on the same cycle as the last tick → hit, not miss.
- 5 hits → window 180; 5×8 further hits → window floors at 40. Score after 120 hits = 99.
- Three misses → lives=0, game_over=1, no arrow_take. state=2 → IDLE, score=0, lives=3, window=200. rst_n=0 mid-ARMED → all outputs reset next edge.
